// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, combinational imem read, DEPTH-entry {pc, instr} queue to ID.
// Define IF_PERF_EN to add the perf_fetch / perf_flush event counters.
module if_fetch_queue #(
    parameter int unsigned WORD_LEN    = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned INSTR_BYTES = 4,
    parameter int unsigned OFF_SHIFT   = 1,
    parameter int unsigned RESET_PC    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       br_taken,
    input  logic                       jump_en,
    input  logic [WORD_LEN-1:0]        br_base,
    input  logic [WORD_LEN-1:0]        br_offset,
    output logic [WORD_LEN-1:0]        imem_addr,
    input  logic [WORD_LEN-1:0]        imem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WORD_LEN-1:0]        out_pc,
    output logic [WORD_LEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]     q_count
`ifdef IF_PERF_EN
    ,
    output logic [31:0]                perf_fetch,
    output logic [31:0]                perf_flush
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WORD_LEN-1:0] mem_pc_q    [DEPTH];
    logic [WORD_LEN-1:0] mem_instr_q [DEPTH];

    logic                redirect, pop, push;
    logic [WORD_LEN-1:0] off_sh, target;

    always_comb begin
        redirect = br_taken | jump_en;
        off_sh   = br_offset << OFF_SHIFT;
        target   = jump_en ? off_sh : br_base + off_sh;
        pop      = out_valid & out_ready & ~redirect;
        push     = ~freeze & ~redirect & ((cnt_q < CW'(DEPTH)) | pop);

        pc_d   = pc_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (redirect) begin
            // Flush by collapsing tail onto head; a same-cycle pop is discarded too.
            pc_d   = target;
            tail_d = head_q;
            cnt_d  = '0;
        end else begin
            if (push) pc_d = pc_q + WORD_LEN'(INSTR_BYTES);
            head_d = head_q + PW'(pop);
            tail_d = tail_q + PW'(push);
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= WORD_LEN'(RESET_PC);
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]    <= '0;
                mem_instr_q[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            if (push) begin
                mem_pc_q[tail_q]    <= pc_q;
                mem_instr_q[tail_q] <= imem_data;
            end
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = (cnt_q != '0);
    assign out_pc    = mem_pc_q[head_q];
    assign out_instr = mem_instr_q[head_q];
    assign q_count   = cnt_q;

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (push) perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redirect && cnt_q != '0) perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (default parameters, imem_data = addr ^ 16'hA5A5).
module tb_if_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, br_taken, jump_en, out_ready;
    logic [15:0] br_base, br_offset, imem_addr, imem_data, out_pc, out_instr;
    logic        out_valid;
    logic [2:0]  q_count;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch, perf_flush;
`endif

    int asserts = 0;
    int fails   = 0;

    if_fetch_queue #(.WORD_LEN(16), .DEPTH(4), .INSTR_BYTES(4), .OFF_SHIFT(1), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .br_taken(br_taken), .jump_en(jump_en),
        .br_base(br_base), .br_offset(br_offset), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .q_count(q_count)
`ifdef IF_PERF_EN
        , .perf_fetch(perf_fetch), .perf_flush(perf_flush)
`endif
    );

    assign imem_data = imem_addr ^ 16'hA5A5;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(q_count), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; br_taken = 1'b0; jump_en = 1'b0;
        out_ready = 1'b1; br_base = '0; br_offset = '0;
        #2;
        check("init_valid", 32'(out_valid), 32'd0);
        check("init_count", 32'(q_count), 32'd0);
        check("init_addr", 32'(imem_addr), 32'h0);
        check("init_pc", 32'(out_pc), 32'h0);
        check("init_instr", 32'(out_instr), 32'h0);
`ifdef IF_PERF_EN
        check("init_perf_fetch", perf_fetch, 32'd0);
        check("init_perf_flush", perf_flush, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming: one entry per cycle, occupancy stays at 1
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_pc", 32'(out_pc), 32'(k * 4));
            check("stream_instr", 32'(out_instr), 32'(16'(k * 4) ^ 16'hA5A5));
            check("stream_count", 32'(q_count), 32'd1);
        end

        // Back-pressure fills the queue, PC stops at 16
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 4) check("fill_count", 32'(q_count), 32'(k));
        end
        check("full_count", 32'(q_count), 32'd4);
        check("full_addr", 32'(imem_addr), 32'h10);
        check("full_pc", 32'(out_pc), 32'h0);
        check("full_instr", 32'(out_instr), 32'hA5A5);
        check("full_valid", 32'(out_valid), 32'd1);

        // Full with pop: simultaneous push, count unchanged
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullpop_count", 32'(q_count), 32'd4);
        check("fullpop_pc", 32'(out_pc), 32'h4);
        check("fullpop_addr", 32'(imem_addr), 32'h14);

        // Relative branch: 8 + (6<<1) = 20
        br_taken = 1'b1; br_base = 16'h8; br_offset = 16'h6;
        tick();
        br_taken = 1'b0;
        check("br_valid", 32'(out_valid), 32'd0);
        check("br_count", 32'(q_count), 32'd0);
        check("br_addr", 32'(imem_addr), 32'h14);
`ifdef IF_PERF_EN
        check("perf_fetch_br", perf_fetch, 32'd5);
        check("perf_flush_br", perf_flush, 32'd1);
`endif
        out_ready = 1'b1;
        tick();
        check("br_out_pc", 32'(out_pc), 32'h14);
        check("br_out_instr", 32'(out_instr), 32'hA5B1);

        // Jump wins over branch, with and without freeze
        br_taken = 1'b1; jump_en = 1'b1; br_base = 16'h100; br_offset = 16'h0010;
        tick();
        check("jmp_addr", 32'(imem_addr), 32'h20);
        check("jmp_valid", 32'(out_valid), 32'd0);
        freeze = 1'b1;
        tick();
        check("jmpfrz_addr", 32'(imem_addr), 32'h20);
        check("jmpfrz_count", 32'(q_count), 32'd0);
        br_taken = 1'b0; jump_en = 1'b0;
        tick();
        check("frz_addr", 32'(imem_addr), 32'h20);
        check("frz_count", 32'(q_count), 32'd0);
        freeze = 1'b0;

        // PC wrap: jump to 0xFFFC then sequential fetch wraps to 0
        jump_en = 1'b1; br_offset = 16'h7FFE;
        tick();
        jump_en = 1'b0;
        check("wrapjmp_addr", 32'(imem_addr), 32'hFFFC);
        tick();
        check("wrap_addr", 32'(imem_addr), 32'h0);
        check("wrap_pc", 32'(out_pc), 32'hFFFC);

        // Branch sum truncation: 0xFFF0 + 0x20 = 0x0010
        br_taken = 1'b1; br_base = 16'hFFF0; br_offset = 16'h0010;
        tick();
        br_taken = 1'b0;
        check("brwrap_addr", 32'(imem_addr), 32'h10);

        // Freeze drains three entries without fetching
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        check("pre_frz_count", 32'(q_count), 32'd3);
        check("pre_frz_addr", 32'(imem_addr), 32'h1C);
        freeze = 1'b1; out_ready = 1'b1;
        tick();
        check("drain1_pc", 32'(out_pc), 32'h14);
        check("drain1_count", 32'(q_count), 32'd2);
        tick();
        check("drain2_pc", 32'(out_pc), 32'h18);
        tick();
        check("drain3_valid", 32'(out_valid), 32'd0);
        check("drain3_count", 32'(q_count), 32'd0);
        check("drain3_addr", 32'(imem_addr), 32'h1C);

        // Asynchronous reset mid-run
        freeze = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        check("midrun_count", 32'(q_count), 32'd2);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(q_count), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'h0);
`ifdef IF_PERF_EN
        check("midrst_perf_fetch", perf_fetch, 32'd0);
        check("midrst_perf_flush", perf_flush, 32'd0);
`endif
        tick();
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
